mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed memory responder: the target end of the CPU memory bus (MAR / MBR_W / MBR_R / write).
- Latches one request per transaction and inserts a fixed number of wait states.
- Commits a write, or returns registered read data, then pulses ready for one cycle.
- Sits between the CPU and on-chip storage, replacing the zero-latency combinational memory model.

Parameters:
BITS_DATA, 32, data word width
BITS_ADDR, 16, bus address width (64Ki word space)
DEPTH_LOG2, 10, log2 of physical words implemented (1024)
WAIT_STATES, 1, extra cycles between request capture and response (0..15)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
req  input  1  request strobe; sampled only in IDLE
write  input  1  1 = write, 0 = read; sampled with req
MAR  input  BITS_ADDR  word address; sampled with req
MBR_W  input  BITS_DATA  write data; sampled with req
MBR_R  output  BITS_DATA  read data; valid when ready=1 for a read
ready  output  1  one-cycle completion pulse
busy  output  1  high from request capture until the ready cycle (inclusive)
err  output  1  high with ready when the address is out of range

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state=IDLE, MBR_R=0, ready=0, busy=0, err=0, wait counter=0.
  - Storage array contents are not cleared.
- States:
  - IDLE:
    - On a clk edge with req=1, capture MAR, MBR_W and write into addr_q, wdata_q and wr_q; busy=1.
    - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
    - WAIT_STATES=0: go to RESP.
  - WAIT:
    - Counter decrements each cycle.
    - At counter=0, go to RESP.
  - RESP:
    - ready=1 for exactly one cycle, then return to IDLE; busy drops in the following cycle.
- Latency: ready asserts WAIT_STATES+1 cycles after the edge that sampled req.
- Range check: in range iff addr_q[BITS_ADDR-1:DEPTH_LOG2]==0. Out of range:
  - Writes are dropped.
  - Reads return MBR_R=0.
  - err=1 during the ready cycle only.
- Write: the array is updated at the edge entering RESP, using addr_q[DEPTH_LOG2-1:0] and wdata_q. MBR_R is unchanged by writes.
- Read:
  - MBR_R is registered, loaded at the edge entering RESP.
  - It holds its value until the next read response.
- Request timing:
  - req asserted while busy (WAIT or RESP) is ignored, not queued.
  - The requester must hold req until ready, or re-assert it after ready.
- Same-cycle read-after-write: a read issued the cycle after a write's ready returns the new data (the array write has completed).
- Reset mid-transaction (WAIT or RESP):
  - Aborts the transaction; no ready pulse.
  - A pending write in WAIT is never committed.
  - A write already committed at RESP entry stays committed.
- Bus inputs are don't-care outside the req-sampling edge.

Optional Feature:
- MEM_PARITY_EN defined:
  - Each stored word carries an even-parity bit computed from wdata_q at commit.
  - On a read, the parity is recomputed. A mismatch asserts output perr (1 bit, reset 0) for the ready cycle only; MBR_R still returns the stored data.
  - Out-of-range reads: perr=0.
  - A bench hook input inject_perr (1 bit) inverts the stored parity bit of the word written while it is high.
- MEM_PARITY_EN not defined: perr and inject_perr ports are absent, with no parity storage or logic.

Decomposition:
- Package mem_pkg:
  - State encoding constants ST_IDLE=0, ST_WAIT=1, ST_RESP=2.
  - Default widths BITS_DATA/BITS_ADDR.
  - Wait-counter width (4).
  - Parity function (used only under MEM_PARITY_EN).
- Sub-module mem_array:
  - Single-port storage with synchronous write and synchronous read, indexed by DEPTH_LOG2 bits.
  - Parity column only under MEM_PARITY_EN.
  - mem_responder holds the FSM, capture registers, range check and outputs.

Test Plan:
- Reset with reset_n=0 mid-WAIT of a write to 0x0005 data 0xDEADBEEF -> ready never pulses; a later read of 0x0005 returns the prior contents, not 0xDEADBEEF; all outputs 0 during reset.
- WAIT_STATES=1: write 0x0010 <- 0x12345678, then read 0x0010 -> each ready arrives 2 cycles after req; the read returns MBR_R=0x12345678, err=0.
- WAIT_STATES=0 back-to-back: write 0x03FF <- 0xA5A5A5A5, then read 0x03FF issued the cycle after ready -> read ready 1 cycle after req, MBR_R=0xA5A5A5A5.
- Out of range (DEPTH_LOG2=10): write 0x0400 <- 0x1, then read 0x0400 -> both ready with err=1; the read gives MBR_R=0; a read of 0x0000 is unchanged.
- req held high through WAIT and RESP, with MAR changed to 0x0020 mid-WAIT -> the response uses the captured address; the second transaction starts only on the IDLE edge; exactly one ready per captured request.
- MEM_PARITY_EN: write 0x0007 <- 0x00000001 with inject_perr=1, then read 0x0007 -> ready with perr=1, MBR_R=0x00000001; rewrite with inject_perr=0 -> read gives perr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM encoding, default widths, wait-counter width.
// The parity helper exists only when MEM_PARITY_EN is defined.
package mem_pkg;

  localparam int DEF_BITS_DATA = 32;
  localparam int DEF_BITS_ADDR = 16;
  localparam int CNT_W         = 4;
  localparam int PAR_MAX_W     = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

`ifdef MEM_PARITY_EN
  // Even parity: data plus this bit always holds an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus: request strobe, direction, address, write/read data and completion status.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int BITS_DATA = DEF_BITS_DATA,
  parameter int BITS_ADDR = DEF_BITS_ADDR
);

  logic                 req;
  logic                 write;
  logic [BITS_ADDR-1:0] MAR;
  logic [BITS_DATA-1:0] MBR_W;
  logic [BITS_DATA-1:0] MBR_R;
  logic                 ready;
  logic                 busy;
  logic                 err;

  modport master (
    output req, write, MAR, MBR_W,
    input  MBR_R, ready, busy, err
  );

  modport slave (
    input  req, write, MAR, MBR_W,
    output MBR_R, ready, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage with synchronous write and registered synchronous read.
// With MEM_PARITY_EN a parity column is stored and checked on every read.
module mem_array
  import mem_pkg::*;
#(
  parameter int BITS_DATA  = DEF_BITS_DATA,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  rzero_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [BITS_DATA-1:0]  wdata_i,
  output logic [BITS_DATA-1:0]  rdata_o
`ifdef MEM_PARITY_EN
  , input  logic                inj_i
  , output logic                perr_o
`endif
);

  logic [BITS_DATA-1:0] mem_q [2**DEPTH_LOG2];
  logic [BITS_DATA-1:0] rdata_q;

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: loads only on a read, zero for out-of-range reads, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {BITS_DATA{1'b0}};
    end else if (re_i) begin
      rdata_q <= rzero_i ? {BITS_DATA{1'b0}} : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef MEM_PARITY_EN
  logic par_q [2**DEPTH_LOG2];
  logic perr_q;

  // Parity column written alongside the data; inj_i flips the stored bit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      par_q[addr_i] <= even_parity(PAR_MAX_W'(wdata_i)) ^ inj_i;
    end
  end

  // Parity error is a one-cycle flag tied to the read that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= re_i && !rzero_i &&
                (even_parity(PAR_MAX_W'(mem_q[addr_i])) != par_q[addr_i]);
    end
  end

  assign perr_o = perr_q;
`endif

endmodule

// File: rtl/mem_responder.sv
// Memory bus target: captures one request, waits WAIT_STATES cycles, commits or reads, pulses ready.
// Optional stored-word parity checking is enabled by defining MEM_PARITY_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int BITS_DATA   = DEF_BITS_DATA,
  parameter int BITS_ADDR   = DEF_BITS_ADDR,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            reset_n,
  mem_responder_if.slave bus
`ifdef MEM_PARITY_EN
  , input  logic         inject_perr
  , output logic         perr
`endif
);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITS_ADDR-1:0] addr_q, addr_d;
  logic [BITS_DATA-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 ready_q, busy_q, err_q;
  logic                 enter_resp_s, in_range_s;

  // Next-state logic; the request is only sampled while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.MAR;
          wdata_d = bus.MBR_W;
          wr_d    = bus.write;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decisions at the RESP-entry edge use the _d copies so a zero-wait capture is seen in time.
  assign enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign in_range_s   = (addr_d[BITS_ADDR-1:DEPTH_LOG2] == {(BITS_ADDR-DEPTH_LOG2){1'b0}});

  // FSM, capture and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {BITS_ADDR{1'b0}};
      wdata_q <= {BITS_DATA{1'b0}};
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= enter_resp_s;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= enter_resp_s && !in_range_s;
    end
  end

  mem_array #(
    .BITS_DATA  (BITS_DATA),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset_n),
    .we_i    (enter_resp_s && wr_d && in_range_s),
    .re_i    (enter_resp_s && !wr_d),
    .rzero_i (!in_range_s),
    .addr_i  (addr_d[DEPTH_LOG2-1:0]),
    .wdata_i (wdata_d),
    .rdata_o (bus.MBR_R)
`ifdef MEM_PARITY_EN
    , .inj_i  (inject_perr)
    , .perr_o (perr)
`endif
  );

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with one wait state (dut1) and one with none (dut0).
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus1 ();
  mem_responder_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus0 ();

`ifdef MEM_PARITY_EN
  logic inj1, perr1, inj0, perr0;
`endif

  mem_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_LOG2(10), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
`ifdef MEM_PARITY_EN
    , .inject_perr(inj1), .perr(perr1)
`endif
  );

  mem_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
`ifdef MEM_PARITY_EN
    , .inject_perr(inj0), .perr(perr0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on dut1 (sel=1) or dut0 (sel=0): req is driven on the negedge after the call
  // and held until ready; lat counts posedges from req to ready (20 means no ready).
  task automatic xact(input bit sel, input logic wr, input logic [15:0] addr, input logic [31:0] data,
                      output int lat, output logic [31:0] rd, output logic e, output logic pe);
    logic rdy;
    lat = 0;
    rdy = 1'b0;
    @(negedge clk);
    if (sel) begin
      bus1.req = 1'b1; bus1.write = wr; bus1.MAR = addr; bus1.MBR_W = data;
    end else begin
      bus0.req = 1'b1; bus0.write = wr; bus0.MAR = addr; bus0.MBR_W = data;
    end
    while (!rdy && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      rdy = sel ? bus1.ready : bus0.ready;
    end
    rd = sel ? bus1.MBR_R : bus0.MBR_R;
    e  = sel ? bus1.err : bus0.err;
`ifdef MEM_PARITY_EN
    pe = sel ? perr1 : perr0;
`else
    pe = 1'b0;
`endif
    bus1.req = 1'b0;
    bus0.req = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd, rd_a, rd_b;
  logic        e, pe, ready_seen;
  logic [6:0]  rdy_v, busy_v;

  initial begin
    reset_n = 1'b0;
    bus1.req = 1'b0; bus1.write = 1'b0; bus1.MAR = 16'h0000; bus1.MBR_W = 32'h0;
    bus0.req = 1'b0; bus0.write = 1'b0; bus0.MAR = 16'h0000; bus0.MBR_W = 32'h0;
`ifdef MEM_PARITY_EN
    inj1 = 1'b0; inj0 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst1_ready", 32'(bus1.ready), 32'd0);
    check("rst1_busy",  32'(bus1.busy),  32'd0);
    check("rst1_err",   32'(bus1.err),   32'd0);
    check("rst1_mbr",   bus1.MBR_R,      32'd0);
    check("rst0_ready", 32'(bus0.ready), 32'd0);
    check("rst0_busy",  32'(bus0.busy),  32'd0);
    check("rst0_mbr",   bus0.MBR_R,      32'd0);
    reset_n = 1'b1;

    // One wait state: write then read back
    xact(1'b1, 1'b1, 16'h0010, 32'h12345678, lat, rd, e, pe);
    check("ws1_wr_lat", 32'(lat), 32'd2);
    check("ws1_wr_err", 32'(e), 32'd0);
    xact(1'b1, 1'b0, 16'h0010, 32'h0, lat, rd, e, pe);
    check("ws1_rd_lat",  32'(lat), 32'd2);
    check("ws1_rd_data", rd, 32'h12345678);
    check("ws1_rd_err",  32'(e), 32'd0);
    @(negedge clk);
    check("ready_pulse_end", 32'(bus1.ready), 32'd0);
    check("busy_after_rdy",  32'(bus1.busy),  32'd0);

    // Reset mid-WAIT of a write
    xact(1'b1, 1'b1, 16'h0005, 32'h11111111, lat, rd, e, pe);
    check("wr_keeps_mbr", rd, 32'h12345678);
    @(negedge clk);
    bus1.req = 1'b1; bus1.write = 1'b1; bus1.MAR = 16'h0005; bus1.MBR_W = 32'hDEADBEEF;
    @(posedge clk);
    #2 reset_n = 1'b0;
    bus1.req = 1'b0;
    ready_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ready_seen = ready_seen | bus1.ready;
    end
    check("midrst_ready", 32'(ready_seen), 32'd0);
    check("midrst_busy",  32'(bus1.busy),  32'd0);
    check("midrst_err",   32'(bus1.err),   32'd0);
    check("midrst_mbr",   bus1.MBR_R,      32'd0);
    reset_n = 1'b1;
    xact(1'b1, 1'b0, 16'h0005, 32'h0, lat, rd, e, pe);
    check("midrst_nocommit", rd, 32'h11111111);

    // Zero wait states, back-to-back at the top in-range word
    xact(1'b0, 1'b1, 16'h03FF, 32'hA5A5A5A5, lat, rd, e, pe);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    check("ws0_busy_at_rdy", 32'(bus0.busy), 32'd1);
    xact(1'b0, 1'b0, 16'h03FF, 32'h0, lat, rd, e, pe);
    check("ws0_rd_lat",  32'(lat), 32'd1);
    check("ws0_rd_data", rd, 32'hA5A5A5A5);
    check("ws0_rd_err",  32'(e), 32'd0);

    // Out of range: first word above the implemented space
    xact(1'b1, 1'b1, 16'h0000, 32'hCAFEF00D, lat, rd, e, pe);
    xact(1'b1, 1'b1, 16'h0400, 32'h00000001, lat, rd, e, pe);
    check("oor_wr_lat", 32'(lat), 32'd2);
    check("oor_wr_err", 32'(e), 32'd1);
    xact(1'b1, 1'b0, 16'h0400, 32'h0, lat, rd, e, pe);
    check("oor_rd_err",  32'(e), 32'd1);
    check("oor_rd_data", rd, 32'h0);
    check("oor_rd_perr", 32'(pe), 32'd0);
    @(negedge clk);
    check("oor_err_pulse", 32'(bus1.err), 32'd0);
    xact(1'b1, 1'b0, 16'h0000, 32'h0, lat, rd, e, pe);
    check("oor_no_alias", rd, 32'hCAFEF00D);
    check("oor_base_err", 32'(e), 32'd0);

    // req held through WAIT/RESP with MAR changed mid-WAIT
    xact(1'b1, 1'b1, 16'h0020, 32'h20202020, lat, rd, e, pe);
    @(negedge clk);
    bus1.req = 1'b1; bus1.write = 1'b0; bus1.MAR = 16'h0010;
    rdy_v = 7'd0; busy_v = 7'd0; rd_a = 32'h0; rd_b = 32'h0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      rdy_v[i]  = bus1.ready;
      busy_v[i] = bus1.busy;
      if (i == 0) bus1.MAR = 16'h0020;
      if (i == 1) rd_a = bus1.MBR_R;
      if (i == 4) begin
        rd_b = bus1.MBR_R;
        bus1.req = 1'b0;
      end
    end
    check("hold_ready_seq", 32'(rdy_v),  32'(7'b0010010));
    check("hold_busy_seq",  32'(busy_v), 32'(7'b0011011));
    check("hold_first_rd",  rd_a, 32'h12345678);
    check("hold_second_rd", rd_b, 32'h20202020);

`ifdef MEM_PARITY_EN
    inj1 = 1'b1;
    xact(1'b1, 1'b1, 16'h0007, 32'h00000001, lat, rd, e, pe);
    inj1 = 1'b0;
    xact(1'b1, 1'b0, 16'h0007, 32'h0, lat, rd, e, pe);
    check("par_inj_perr", 32'(pe), 32'd1);
    check("par_inj_data", rd, 32'h00000001);
    xact(1'b1, 1'b1, 16'h0007, 32'h00000001, lat, rd, e, pe);
    xact(1'b1, 1'b0, 16'h0007, 32'h0, lat, rd, e, pe);
    check("par_clean_perr", 32'(pe), 32'd0);
    check("par_clean_data", rd, 32'h00000001);
    @(negedge clk);
    check("par_perr_pulse", 32'(perr1), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
